// File: rtl/button_event_arbiter.sv
// Debounced push-button press detector with a round-robin single-event offer channel.
// Each press latches a per-channel pending flag. A valid/ready handshake hands the flags out one at a time.
module button_event_arbiter #(
  parameter int N_BTN      = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_in,
  input  logic                     evt_ready,
  input  logic                     ovr_clr,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic [N_BTN-1:0]         pending,
  output logic                     evt_overrun
);

  localparam int IDW = $clog2(N_BTN);
  localparam int CW  = $clog2(DEB_CYCLES);

  typedef enum logic [0:0] {IDLE = 1'b0, OFFER = 1'b1} state_t;

  logic [N_BTN-1:0] sync1_r, sync2_r, deb_r, deb_q_r;
  logic [CW-1:0]    cnt_r [N_BTN];
  logic [N_BTN-1:0] press_s, clr_s, pending_r, pending_n;
  logic [IDW-1:0]   evt_id_r, id_n, last_grant_r, last_n, grant_s, cidx_s;
  logic             evt_valid_r, valid_n, evt_overrun_r, ovr_n, found_s;
  state_t           state_r, state_n;

  // Synchronize raw inputs, then require DEB_CYCLES consecutive disagreeing cycles before a level flips
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
      deb_r   <= '0;
      deb_q_r <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_r[i] <= '0;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
      deb_q_r <= deb_r;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CW'(DEB_CYCLES - 1)) begin
          cnt_r[i] <= '0;
          deb_r[i] <= sync2_r[i];
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  assign press_s = deb_r & ~deb_q_r;

  // Round-robin pick, FSM next state, and next values of every registered output
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    cidx_s  = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      cidx_s  = IDW'((int'(last_grant_r) + k) % N_BTN);
      grant_s = (!found_s && pending_r[cidx_s]) ? cidx_s : grant_s;
      found_s = found_s | pending_r[cidx_s];
    end
    state_n = state_r;
    valid_n = evt_valid_r;
    id_n    = evt_id_r;
    last_n  = last_grant_r;
    clr_s   = '0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_n = OFFER;
          valid_n = 1'b1;
          id_n    = grant_s;
          clr_s   = N_BTN'(1) << grant_s;
        end else begin
          valid_n = 1'b0;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          state_n = IDLE;
          valid_n = 1'b0;
          last_n  = evt_id_r;
        end else begin
          valid_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
    // A press on a channel whose flag is still set is a lost press
    pending_n = (pending_r & ~clr_s) | press_s;
    ovr_n     = (evt_overrun_r & ~ovr_clr) | (|(press_s & pending_r));
  end

  // Arbiter state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      evt_valid_r   <= 1'b0;
      evt_id_r      <= '0;
      last_grant_r  <= IDW'(N_BTN - 1);
      pending_r     <= '0;
      evt_overrun_r <= 1'b0;
    end else begin
      state_r       <= state_n;
      evt_valid_r   <= valid_n;
      evt_id_r      <= id_n;
      last_grant_r  <= last_n;
      pending_r     <= pending_n;
      evt_overrun_r <= ovr_n;
    end
  end

  assign evt_valid   = evt_valid_r;
  assign evt_id      = evt_id_r;
  assign pending     = pending_r;
  assign evt_overrun = evt_overrun_r;

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of push-button channels (2..8).
REQ-002 SHALL have parameter DEB_CYCLES, default 16: consecutive stable cycles required to accept a level change (>=2).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port btn_in  input  N_BTN  raw asynchronous button levels, 1 = pressed.
REQ-006 SHALL have port evt_ready  input  1  consumer accepts the offered event.
REQ-007 SHALL have port ovr_clr  input  1  clears evt_overrun.
REQ-008 SHALL have port evt_valid  output  1  an event is being offered.
REQ-009 SHALL have port evt_id  output  clog2(N_BTN)  channel index of the offered event.
REQ-010 SHALL have port pending  output  N_BTN  per-channel pending-event flags.
REQ-011 SHALL have port evt_overrun  output  1  sticky: a press was lost.

Function
REQ-012 SHALL pass each btn_in bit through a two-flop synchronizer before any other use.
REQ-013 SHALL keep one debounced level per channel; it changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any cycle of agreement restarts the count at 0.
REQ-014 SHALL treat a 0->1 transition of a debounced level as a press; releases (1->0) generate nothing.
REQ-015 SHALL set pending[i] on the cycle after a press on channel i.
REQ-016 SHALL implement FSM states IDLE and OFFER only.
REQ-017 IDLE: if pending != 0, SHALL select one channel round-robin, starting at last_grant+1 modulo N_BTN, load evt_id, clear that pending bit, assert evt_valid, go to OFFER; else stay IDLE.
REQ-018 OFFER: SHALL hold evt_valid=1 and evt_id constant until evt_ready=1; on that cycle the transfer completes, last_grant <= evt_id, FSM goes to IDLE, evt_valid=0 next cycle.
REQ-019 SHALL guarantee at least one idle cycle (evt_valid=0) between consecutive events.
REQ-020 With FSM IDLE and no other pending, evt_valid SHALL first assert exactly DEB_CYCLES+4 clock edges after the first edge that samples btn_in[i]=1 (2 sync + DEB_CYCLES debounce + 1 pending + 1 select), provided btn_in stays high.
REQ-021 A press on channel i while pending[i]=1 SHALL keep pending[i]=1 and set evt_overrun.
REQ-022 A press on the channel currently offered (its pending already cleared) SHALL set pending[i], not evt_overrun.
REQ-023 Presses on several channels in the same cycle SHALL all set pending; service order follows REQ-017.
REQ-024 evt_overrun SHALL stay set until ovr_clr=1; if ovr_clr and a new overrun occur in the same cycle, evt_overrun SHALL be 1.
REQ-025 evt_ready while evt_valid=0 SHALL be ignored.

Reset
REQ-026 On a rising clk edge with rst_n=0: synchronizers, debounced levels, counters, pending, evt_overrun, evt_valid SHALL be 0; evt_id SHALL be 0; FSM IDLE; last_grant = N_BTN-1 (channel 0 highest first priority).
REQ-027 Reset mid-OFFER SHALL drop evt_valid the following cycle and discard all pending events without reporting overrun.
REQ-028 A button held high through reset release SHALL be debounced from level 0 and produce one press.

Verification
REQ-029 Single press: btn_in[2] 0->1, held 40 cycles, evt_ready=1 -> evt_valid high exactly 20 edges later (DEB_CYCLES=16), evt_id=2 for 1 cycle, one event total.
REQ-030 Bounce: btn_in[1] toggles every 5 cycles for 60 cycles then held high -> no event during bounce; exactly one event evt_id=1 after DEB_CYCLES+4 stable cycles.
REQ-031 Simultaneous: btn_in=4'b1111 in one cycle, evt_ready=1 -> evt_id sequence 0,1,2,3, each evt_valid pulse separated by >=1 idle cycle.
REQ-032 Backpressure/overrun: evt_ready=0, press ch0, release, press ch0 again (>=DEB_CYCLES spacing), then press ch0 a third time -> offer held with evt_id=0, pending[0]=1 after second press, evt_overrun=1 after third; ovr_clr=1 one cycle -> evt_overrun=0.
REQ-033 Round-robin: last event ch3, then ch0 and ch3 pressed together -> ch0 served first, then ch3; next simultaneous ch0+ch3 -> ch0 first again (last_grant=3).
REQ-034 Reset mid-offer: evt_valid=1, pending=4'b0110, rst_n=0 one cycle -> evt_valid=0, pending=0, evt_overrun=0 next cycle; no event until a new press.
